// File: rtl/accumulator_pingpong_bank.sv
// ============================================================================
// accumulator_pingpong_bank : double-buffered signed tile accumulator, row-wise drain
// Revision: 1.0
// ============================================================================
`default_nettype none

module accumulator_pingpong_bank #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic                                     in_last_i,
  input  logic [ROWS-1:0][COLS-1:0][IN_WIDTH-1:0]  in_data_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [COLS-1:0][ACC_WIDTH-1:0]           out_data_o,
  output logic [$clog2(ROWS)-1:0]                  out_row_o,
  output logic                                     out_last_o,
  output logic                                     out_overflow_o
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [ACC_WIDTH-1:0] bank_q [2][ROWS][COLS];
  logic [ACC_WIDTH-1:0] bank_d [2][ROWS][COLS];
  logic [1:0]           full_q, full_d;
  logic [1:0]           ovf_q, ovf_d;
  logic                 fill_sel_q, fill_sel_d;
  logic                 drain_sel_q, drain_sel_d;
  logic                 first_q, first_d;
  logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;

  logic                 accept;
  logic                 drain_hs;
  logic                 any_ovf;
  logic [ACC_WIDTH:0]   elem;

  // Returns {overflow, result} for one element: widened add, then clamp or wrap.
  function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] acc,
                                                  input logic [IN_WIDTH-1:0]  din);
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] res;
    ext = ACC_WIDTH'($signed(din));
    sum = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
    ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    res = sum[ACC_WIDTH-1:0];
    if (ovf && (SATURATE != 0)) begin
      res = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return {ovf, res};
  endfunction

  assign in_ready_o     = !full_q[fill_sel_q];
  assign out_valid_o    = full_q[drain_sel_q];
  assign out_row_o      = row_cnt_q;
  assign out_last_o     = (row_cnt_q == LAST_ROW);
  assign out_overflow_o = ovf_q[drain_sel_q];

  assign accept   = in_valid_i && in_ready_o;
  assign drain_hs = out_valid_o && out_ready_i;

  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign out_data_o[c] = bank_q[drain_sel_q][row_cnt_q][c];
  end

  always_comb begin
    bank_d      = bank_q;
    full_d      = full_q;
    ovf_d       = ovf_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    first_d     = first_q;
    row_cnt_d   = row_cnt_q;
    any_ovf     = 1'b0;
    elem        = '0;

    // Fill and drain always target different banks, so both may update in one cycle.
    if (accept) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          elem = acc_add(bank_q[fill_sel_q][r][c], in_data_i[r][c]);
          if (first_q) begin
            bank_d[fill_sel_q][r][c] = ACC_WIDTH'($signed(in_data_i[r][c]));
          end else begin
            bank_d[fill_sel_q][r][c] = elem[ACC_WIDTH-1:0];
            any_ovf = any_ovf | elem[ACC_WIDTH];
          end
        end
      end
      ovf_d[fill_sel_q] = first_q ? 1'b0 : (ovf_q[fill_sel_q] | any_ovf);
      first_d = in_last_i;
      if (in_last_i) begin
        full_d[fill_sel_q] = 1'b1;
        fill_sel_d         = ~fill_sel_q;
      end
    end

    if (drain_hs) begin
      if (row_cnt_q == LAST_ROW) begin
        row_cnt_d           = '0;
        full_d[drain_sel_q] = 1'b0;
        drain_sel_d         = ~drain_sel_q;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            bank_q[b][r][c] <= '0;
          end
        end
      end
      full_q      <= '0;
      ovf_q       <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      first_q     <= 1'b1;
      row_cnt_q   <= '0;
    end else begin
      bank_q      <= bank_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      first_q     <= first_d;
      row_cnt_q   <= row_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_accumulator_pingpong_bank.sv
// ============================================================================
// tb_accumulator_pingpong_bank : directed bench, saturating and wrapping instances
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_accumulator_pingpong_bank;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int IW   = 16;
  localparam int AW   = 20;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid;
  logic in_last;
  logic out_ready;
  logic [ROWS-1:0][COLS-1:0][IW-1:0] in_data;

  logic                  in_ready_s, out_valid_s, out_last_s, out_ovf_s;
  logic [COLS-1:0][AW-1:0] out_data_s;
  logic [1:0]            out_row_s;
  logic                  in_ready_w, out_valid_w, out_last_w, out_ovf_w;
  logic [COLS-1:0][AW-1:0] out_data_w;
  logic [1:0]            out_row_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accumulator_pingpong_bank #(
    .ROWS(ROWS), .COLS(COLS), .IN_WIDTH(IW), .ACC_WIDTH(AW), .SATURATE(1)
  ) dut_s (
    .clk_i(clk), .reset_n_i(reset_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready_s), .in_last_i(in_last), .in_data_i(in_data),
    .out_valid_o(out_valid_s), .out_ready_i(out_ready), .out_data_o(out_data_s),
    .out_row_o(out_row_s), .out_last_o(out_last_s), .out_overflow_o(out_ovf_s)
  );

  accumulator_pingpong_bank #(
    .ROWS(ROWS), .COLS(COLS), .IN_WIDTH(IW), .ACC_WIDTH(AW), .SATURATE(0)
  ) dut_w (
    .clk_i(clk), .reset_n_i(reset_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready_w), .in_last_i(in_last), .in_data_i(in_data),
    .out_valid_o(out_valid_w), .out_ready_i(out_ready), .out_data_o(out_data_w),
    .out_row_o(out_row_w), .out_last_o(out_last_w), .out_overflow_o(out_ovf_w)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        in_data[r][c] = IW'(v);
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input int v, input bit last);
    in_valid = 1'b1;
    in_last  = last;
    set_all(v);
    for (int i = 0; i < 50 && !in_ready_s; i++) step();
    chk("in_ready_wait", in_ready_s, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int r0, input int r1, input longint es, input longint ew,
                       input bit os, input bit ow, input bit rdy0);
    out_ready = 1'b1;
    for (int r = r0; r <= r1; r++) begin
      chk("out_valid_s", out_valid_s, 1);
      chk("out_valid_w", out_valid_w, 1);
      chk("out_row", out_row_s, r);
      chk("out_last", out_last_s, (r == ROWS - 1) ? 1 : 0);
      chk("out_ovf_s", out_ovf_s, os);
      chk("out_ovf_w", out_ovf_w, ow);
      for (int c = 0; c < COLS; c++) begin
        chk("data_s", $signed(out_data_s[c]), es);
        chk("data_w", $signed(out_data_w[c]), ew);
      end
      if (rdy0) chk("in_ready_blocked", in_ready_s, 0);
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    set_all(0);
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    chk("rst_in_ready", in_ready_s, 1);
    chk("rst_out_valid", out_valid_s, 0);
    chk("rst_out_data", out_data_s, 0);
    chk("rst_out_row", out_row_s, 0);
    chk("rst_out_last", out_last_s, 0);
    chk("rst_out_ovf", out_ovf_s, 0);

    // Basic tile: 100 + 200 - 50
    send(100, 0);
    send(200, 0);
    chk("basic_no_early_valid", out_valid_s, 0);
    send(-50, 1);
    chk("basic_latency", out_valid_s, 1);
    drain(0, 3, 250, 250, 0, 0, 0);
    chk("basic_drained", out_valid_s, 0);

    // 16 beats of 32767: exact fit, no overflow
    for (int i = 0; i < 16; i++) send(32767, i == 15);
    drain(0, 3, 524272, 524272, 0, 0, 0);

    // 17 beats of 32767: clamp vs wrap
    for (int i = 0; i < 17; i++) send(32767, i == 16);
    drain(0, 3, 524287, -491537, 1, 1, 0);

    // 17 beats of -32768: negative clamp vs wrap
    for (int i = 0; i < 17; i++) send(-32768, i == 16);
    drain(0, 3, -524288, 491520, 1, 1, 0);

    // Single-beat tile clears the sticky flag
    send(1, 1);
    drain(0, 3, 1, 1, 0, 0, 0);

    // Ping-pong backpressure
    send(5, 1);
    send(9, 1);
    chk("pp_in_ready_low", in_ready_s, 0);
    in_valid = 1'b1;
    in_last  = 1'b1;
    set_all(3);
    step();
    step();
    chk("pp_stall_ready", in_ready_s, 0);
    chk("pp_stall_row", out_row_s, 0);
    chk("pp_stall_data", $signed(out_data_s[0]), 5);
    drain(0, 3, 5, 5, 0, 0, 1);
    chk("pp_ready_back", in_ready_s, 1);
    drain(0, 0, 9, 9, 0, 0, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("pp_full_again", in_ready_s, 0);
    drain(1, 3, 9, 9, 0, 0, 0);
    drain(0, 3, 3, 3, 0, 0, 0);
    chk("pp_drained", out_valid_s, 0);

    // Final beat of B coincides with A's final-row handshake
    send(2, 1);
    send(4, 0);
    drain(0, 2, 2, 2, 0, 0, 0);
    in_valid = 1'b1;
    in_last  = 1'b1;
    set_all(6);
    chk("sim_in_ready", in_ready_s, 1);
    drain(3, 3, 2, 2, 0, 0, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain(0, 3, 10, 10, 0, 0, 0);
    chk("sim_drained", out_valid_s, 0);

    // Reset mid-drain
    send(8, 1);
    drain(0, 1, 8, 8, 0, 0, 0);
    chk("rmd_row2", out_row_s, 2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rmd_out_valid", out_valid_s, 0);
    chk("rmd_in_ready", in_ready_s, 1);
    chk("rmd_out_row", out_row_s, 0);
    send(7, 1);
    drain(0, 3, 7, 7, 0, 0, 0);
    chk("rmd_drained", out_valid_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
